axil2iob: RTL

- AXI4-Lite slave that converts each AXI4-Lite transaction into one native (IOb) bus request.
- Lets native peripherals sit behind an AXI4-Lite interconnect; complements the existing native-to-AXI4-Lite master bridge.
- Handles one transaction at a time. Read and write channels are arbitrated fairly.
- Returns the native response on the AXI B or R channel.

---
 rtl/axil2iob_pkg.sv | 15 +
 rtl/axil2iob_timer.sv | 26 ++
 rtl/axil2iob.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/axil2iob_pkg.sv
// Shared types and constants for the AXI4-Lite to native (IOb) bus bridge.
package axil2iob_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil2iob_timer.sv
// Native request timeout counter; saturates at all-ones until cleared.
module axil2iob_timer #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  assign expired = &cnt_q;

endmodule

// File: rtl/axil2iob.sv
// AXI4-Lite slave that turns each transaction into one native (IOb) request.
// Optional request timeout with SLVERR response: define AXIL2IOB_TIMEOUT_EN.
module axil2iob
  import axil2iob_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [2:0]          S_AXI_AWPROT,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [2:0]          S_AXI_ARPROT,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic                valid,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic                last_rd_q, last_rd_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]   w_strb_q, w_strb_d;

  logic                valid_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [STRB_W-1:0]   wstrb_d;
  logic                bvalid_d, rvalid_d;
  logic [1:0]          bresp_d, rresp_d;
  logic [DATA_W-1:0]   rdata_d;

  logic aw_hs_c, w_hs_c, ar_hs_c, wr_pend_c, wr_go_c;
  logic timer_clear_c, timeout_c;
  logic unused_c;

  // Handshake and arbitration terms: a write wins a tie only after a read.
  assign S_AXI_AWREADY = (state_q == IDLE) && !aw_held_q;
  assign S_AXI_WREADY  = (state_q == IDLE) && !w_held_q;
  assign aw_hs_c       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs_c        = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_pend_c     = (aw_held_q || aw_hs_c) && (w_held_q || w_hs_c);
  assign wr_go_c       = (state_q == IDLE) && wr_pend_c && (!S_AXI_ARVALID || last_rd_q);
  assign S_AXI_ARREADY = (state_q == IDLE) && !wr_go_c;
  assign ar_hs_c       = S_AXI_ARVALID && S_AXI_ARREADY;

`ifdef AXIL2IOB_TIMEOUT_EN
  axil2iob_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_c),
    .en      (valid),
    .expired (timeout_c)
  );
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT};
`else
  localparam int unsigned UNUSED_TIMEOUT_W = TIMEOUT_W;
  assign timeout_c = 1'b0;
  assign unused_c  = ^{S_AXI_AWPROT, S_AXI_ARPROT, timer_clear_c};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      last_rd_q    <= 1'b1;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      valid        <= 1'b0;
      addr         <= '0;
      wdata        <= '0;
      wstrb        <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= AXI_RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= AXI_RESP_OKAY;
      S_AXI_RDATA  <= '0;
    end else begin
      state_q      <= state_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      last_rd_q    <= last_rd_d;
      aw_addr_q    <= aw_addr_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      valid        <= valid_d;
      addr         <= addr_d;
      wdata        <= wdata_d;
      wstrb        <= wstrb_d;
      S_AXI_BVALID <= bvalid_d;
      S_AXI_BRESP  <= bresp_d;
      S_AXI_RVALID <= rvalid_d;
      S_AXI_RRESP  <= rresp_d;
      S_AXI_RDATA  <= rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    aw_held_d     = aw_held_q;
    w_held_d      = w_held_q;
    last_rd_d     = last_rd_q;
    aw_addr_d     = aw_addr_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;
    valid_d       = valid;
    addr_d        = addr;
    wdata_d       = wdata;
    wstrb_d       = wstrb;
    bvalid_d      = S_AXI_BVALID;
    bresp_d       = S_AXI_BRESP;
    rvalid_d      = S_AXI_RVALID;
    rresp_d       = S_AXI_RRESP;
    rdata_d       = S_AXI_RDATA;
    timer_clear_c = 1'b0;

    if (aw_hs_c) begin
      aw_held_d = 1'b1;
      aw_addr_d = S_AXI_AWADDR;
    end
    if (w_hs_c) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    case (state_q)
      IDLE: begin
        if (wr_go_c) begin
          // Same-cycle handshakes bypass the holding registers.
          state_d       = WR_REQ;
          valid_d       = 1'b1;
          addr_d        = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
          wdata_d       = w_held_q ? w_data_q : S_AXI_WDATA;
          wstrb_d       = w_held_q ? w_strb_q : S_AXI_WSTRB;
          timer_clear_c = 1'b1;
        end else if (ar_hs_c) begin
          state_d       = RD_REQ;
          valid_d       = 1'b1;
          addr_d        = S_AXI_ARADDR;
          wstrb_d       = '0;
          timer_clear_c = 1'b1;
        end
      end
      WR_REQ: begin
        if (valid && (ready || timeout_c)) begin
          state_d   = WR_RESP;
          valid_d   = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = ready ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          last_rd_d = 1'b0;
        end
      end
      RD_REQ: begin
        if (valid && (ready || timeout_c)) begin
          state_d   = RD_RESP;
          valid_d   = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = ready ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          rdata_d   = ready ? rdata : '0;
          last_rd_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      RD_RESP: begin
        if (S_AXI_RREADY) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
